// File: rtl/input_debounce.sv
// Debounce + edge detect for synchronized control inputs.
// Define EDGE_COUNT_EN to build the saturating rise-event counter.
module input_debounce #(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RST_VAL       = 1'b0,
  parameter int   CNT_W         = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sync_in,
  input  logic             clear,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_count
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {
    STABLE,
    QUALIFY
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            accept;
  logic            level_d, rise_d, fall_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= STABLE;
      cnt   <= '0;
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      level <= level_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    case (state)
      STABLE: begin
        cnt_d = '0;
        if (sync_in != level) begin
          // A single-cycle qualify window accepts on first sight
          if (STABLE_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            state_d = QUALIFY;
            cnt_d   = CW'(1);
          end
        end
      end
      QUALIFY: begin
        if (sync_in == level) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt == LAST) begin
          accept  = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d = accept ? ~level : level;
    rise_d  = accept & ~level;
    fall_d  = accept & level;
  end

`ifdef EDGE_COUNT_EN
  logic [CNT_W-1:0] ecnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ecnt <= '0;
    end else if (clear) begin
      ecnt <= '0;
    end else if (rise_d && (ecnt != '1)) begin
      ecnt <= ecnt + CNT_W'(1);
    end
  end

  assign edge_count = ecnt;
`else
  logic unused_clear;

  assign unused_clear = clear;
  assign edge_count   = '0;
`endif

endmodule
